id_hazard_stage: RTL and testbench

- Parametrised decode-stage core: owns the ID pipeline latch (valid/allowin handshake, flush) and the operand path.
- Generic N-producer forwarding with load-use interlock, N read ports, and a register scoreboard for long-latency (multi-cycle divide) results.
- Sits between fetch and execute. Instruction decode logic is external: it reads stage_payload and returns source and destination info combinationally.

---
 rtl/id_hazard_stage_if.sv | 49 ++++
 rtl/id_hazard_stage.sv | 119 +++++++++++
 tb/tb_id_hazard_stage.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_stage_if.sv
// Decode-stage signal bundle: fetch handshake, decoder info, forwarding network,
// long-op completion and EXE handshake. slave = the decode stage, master = its environment.
interface id_hazard_stage_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned PAY_W    = 64,
    parameter int unsigned NUM_RP   = 2,
    parameter int unsigned NUM_FWD  = 3,
    parameter int unsigned MAX_LONG = 4
);
    localparam int unsigned CNT_W = $clog2(MAX_LONG + 1);

    logic                        in_valid;
    logic                        in_allowin;
    logic [PAY_W-1:0]            in_payload;
    logic                        flush;
    logic [PAY_W-1:0]            stage_payload;
    logic [NUM_RP*ADDR_W-1:0]    src_addr;
    logic [NUM_RP-1:0]           src_need;
    logic                        dst_we;
    logic [ADDR_W-1:0]           dst_addr;
    logic                        is_long;
    logic [NUM_RP*DATA_W-1:0]    rf_rdata;
    logic [NUM_FWD-1:0]          fwd_we;
    logic [NUM_FWD*ADDR_W-1:0]   fwd_addr;
    logic [NUM_FWD*DATA_W-1:0]   fwd_data;
    logic [NUM_FWD-1:0]          fwd_pending;
    logic                        long_done;
    logic [ADDR_W-1:0]           long_done_addr;
    logic [NUM_RP*DATA_W-1:0]    src_value;
    logic                        out_valid;
    logic                        out_allowin;
    logic                        stall;
    logic [CNT_W-1:0]            long_cnt;

    modport slave (
        input  in_valid, in_payload, flush, src_addr, src_need, dst_we, dst_addr, is_long,
               rf_rdata, fwd_we, fwd_addr, fwd_data, fwd_pending, long_done, long_done_addr,
               out_allowin,
        output in_allowin, stage_payload, src_value, out_valid, stall, long_cnt
    );

    modport master (
        output in_valid, in_payload, flush, src_addr, src_need, dst_we, dst_addr, is_long,
               rf_rdata, fwd_we, fwd_addr, fwd_data, fwd_pending, long_done, long_done_addr,
               out_allowin,
        input  in_allowin, stage_payload, src_value, out_valid, stall, long_cnt
    );
endinterface

// File: rtl/id_hazard_stage.sv
// Decode-stage latch with N-producer operand forwarding, load-use interlock and a
// register scoreboard that tracks outstanding long-latency (divide) results.
module id_hazard_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned PAY_W    = 64,
    parameter int unsigned NUM_RP   = 2,
    parameter int unsigned NUM_FWD  = 3,
    parameter int unsigned MAX_LONG = 4
) (
    input logic              clk,
    input logic              resetn,
    id_hazard_stage_if.slave bus_io
);
    localparam int unsigned CNT_W   = $clog2(MAX_LONG + 1);
    localparam int unsigned NUM_REG = 2 ** ADDR_W;

    logic               valid_q, valid_d;
    logic [PAY_W-1:0]   payload_q, payload_d;
    logic [NUM_REG-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]        sa      [NUM_RP];
    logic                     hit     [NUM_RP];
    logic                     pend    [NUM_RP];
    logic [DATA_W-1:0]        val     [NUM_RP];
    logic [NUM_RP-1:0]        port_hold;
    logic [NUM_RP*DATA_W-1:0] src_value;

    logic waw, cnt_full, stall, out_valid, in_allowin, fire, cnt_inc, cnt_dec;

    // Scan producers oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        port_hold = '0;
        src_value = '0;
        for (int p = 0; p < int'(NUM_RP); p++) begin
            sa[p]   = bus_io.src_addr[p*ADDR_W +: ADDR_W];
            hit[p]  = 1'b0;
            pend[p] = 1'b0;
            val[p]  = bus_io.rf_rdata[p*DATA_W +: DATA_W];
            for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
                if (bus_io.fwd_we[i] && bus_io.fwd_addr[i*ADDR_W +: ADDR_W] == sa[p]) begin
                    hit[p]  = 1'b1;
                    pend[p] = bus_io.fwd_pending[i];
                    val[p]  = bus_io.fwd_data[i*DATA_W +: DATA_W];
                end
            end
            if (sa[p] == '0) begin
                hit[p]  = 1'b0;
                pend[p] = 1'b0;
                val[p]  = '0;
            end
            src_value[p*DATA_W +: DATA_W] = val[p];
            port_hold[p] = bus_io.src_need[p] & ((hit[p] & pend[p]) | sb_q[sa[p]]);
        end
    end

    always_comb begin
        waw        = bus_io.dst_we & (bus_io.dst_addr != '0) & sb_q[bus_io.dst_addr];
        cnt_full   = bus_io.is_long & (cnt_q == CNT_W'(MAX_LONG));
        stall      = valid_q & ((|port_hold) | waw | cnt_full);
        out_valid  = valid_q & ~stall;
        in_allowin = ~valid_q | (~stall & bus_io.out_allowin);
        fire       = out_valid & bus_io.out_allowin;
    end

    always_comb begin
        valid_d = valid_q;
        if (bus_io.flush) begin
            valid_d = 1'b0;
        end else if (in_allowin) begin
            valid_d = bus_io.in_valid;
        end

        payload_d = payload_q;
        if (bus_io.in_valid && in_allowin && !bus_io.flush) begin
            payload_d = bus_io.in_payload;
        end

        // Clear first, then set, so a coincident set on the same register wins.
        sb_d = sb_q;
        if (bus_io.long_done) begin
            sb_d[bus_io.long_done_addr] = 1'b0;
        end
        if (fire && bus_io.is_long && bus_io.dst_we && bus_io.dst_addr != '0) begin
            sb_d[bus_io.dst_addr] = 1'b1;
        end

        cnt_inc = fire & bus_io.is_long;
        cnt_dec = bus_io.long_done & (cnt_q != '0);
        cnt_d   = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!cnt_inc && cnt_dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus_io.in_allowin    = in_allowin;
    assign bus_io.out_valid     = out_valid;
    assign bus_io.stall         = stall;
    assign bus_io.stage_payload = payload_q;
    assign bus_io.src_value     = src_value;
    assign bus_io.long_cnt      = cnt_q;
endmodule

// File: tb/tb_id_hazard_stage.sv
// Self-checking bench for id_hazard_stage: directed hazard scenarios followed by a
// randomized run, both compared every cycle against a rule-level model.
module tb_id_hazard_stage;
    localparam int MAXL = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    id_hazard_stage_if #(.MAX_LONG(MAXL)) bus ();

    id_hazard_stage #(.MAX_LONG(MAXL)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus_io (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Stimulus
    logic [4:0]  s_src[2];
    logic [1:0]  s_need;
    logic        s_dst_we;
    logic [4:0]  s_dst;
    logic        s_long;
    logic [31:0] s_rf[2];
    logic [2:0]  s_fwe;
    logic [4:0]  s_faddr[3];
    logic [31:0] s_fdata[3];
    logic [2:0]  s_pend;
    logic        s_done;
    logic [4:0]  s_daddr;
    logic        s_inv;
    logic [63:0] s_pay;
    logic        s_flush;
    logic        s_oallow;

    // Model state
    bit          m_valid;
    logic [63:0] m_pay;
    bit [31:0]   m_sb;
    int          m_cnt;
    int          q[$];
    bit          e_allow, e_fire;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stim();
        for (int p = 0; p < 2; p++) begin
            s_src[p] = '0;
            s_rf[p]  = '0;
        end
        for (int i = 0; i < 3; i++) begin
            s_faddr[i] = '0;
            s_fdata[i] = '0;
        end
        s_need = '0; s_dst_we = 0; s_dst = '0; s_long = 0; s_fwe = '0; s_pend = '0;
        s_done = 0; s_daddr = '0; s_inv = 1; s_pay = '0; s_flush = 0; s_oallow = 1;
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_pay = '0;
        m_sb = '0;
        m_cnt = 0;
        q.delete();
    endtask

    task automatic drive_and_check();
        logic [31:0] ev[2];
        bit hold;
        bit e_stall, e_ov;
        bus.in_valid = s_inv;
        bus.in_payload = s_pay;
        bus.flush = s_flush;
        bus.src_addr = {s_src[1], s_src[0]};
        bus.src_need = s_need;
        bus.dst_we = s_dst_we;
        bus.dst_addr = s_dst;
        bus.is_long = s_long;
        bus.rf_rdata = {s_rf[1], s_rf[0]};
        bus.fwd_we = s_fwe;
        bus.fwd_addr = {s_faddr[2], s_faddr[1], s_faddr[0]};
        bus.fwd_data = {s_fdata[2], s_fdata[1], s_fdata[0]};
        bus.fwd_pending = s_pend;
        bus.long_done = s_done;
        bus.long_done_addr = s_daddr;
        bus.out_allowin = s_oallow;
        #1;
        hold = 0;
        for (int p = 0; p < 2; p++) begin
            int win;
            win = -1;
            for (int i = 0; i < 3; i++) begin
                if (s_fwe[i] && s_faddr[i] == s_src[p] && s_src[p] != 0) begin
                    win = i;
                    break;
                end
            end
            ev[p] = (s_src[p] == 0) ? 32'h0 : (win >= 0) ? s_fdata[win] : s_rf[p];
            if (s_need[p] && win >= 0 && s_pend[win]) hold = 1;
            if (s_need[p] && m_sb[s_src[p]]) hold = 1;
        end
        if (s_dst_we && s_dst != 0 && m_sb[s_dst]) hold = 1;
        if (s_long && m_cnt == MAXL) hold = 1;
        e_stall = m_valid && hold;
        e_ov    = m_valid && !e_stall;
        e_allow = !m_valid || (!e_stall && s_oallow);
        e_fire  = e_ov && s_oallow;
        chk("in_allowin", 64'(bus.in_allowin), 64'(e_allow));
        chk("out_valid", 64'(bus.out_valid), 64'(e_ov));
        chk("stall", 64'(bus.stall), 64'(e_stall));
        chk("long_cnt", 64'(bus.long_cnt), 64'(m_cnt));
        chk("stage_payload", bus.stage_payload, m_pay);
        if (m_valid) begin
            chk("src_value0", 64'(bus.src_value[31:0]), 64'(ev[0]));
            chk("src_value1", 64'(bus.src_value[63:32]), 64'(ev[1]));
        end
    endtask

    task automatic advance();
        int old_cnt;
        @(posedge clk);
        old_cnt = m_cnt;
        if (s_done) begin
            m_sb[s_daddr] = 1'b0;
            if (old_cnt > 0) begin
                m_cnt--;
                for (int k = 0; k < q.size(); k++) begin
                    if (q[k] == int'(s_daddr)) begin
                        q.delete(k);
                        break;
                    end
                end
            end
        end
        if (e_fire && s_long) begin
            m_cnt++;
            if (s_dst_we && s_dst != 0) begin
                m_sb[s_dst] = 1'b1;
                q.push_back(int'(s_dst));
            end else begin
                q.push_back(0);
            end
        end
        if (s_inv && e_allow && !s_flush) m_pay = s_pay;
        if (s_flush) m_valid = 0;
        else if (e_allow) m_valid = s_inv;
        @(negedge clk);
    endtask

    task automatic step();
        drive_and_check();
        advance();
    endtask

    initial begin
        clear_stim();
        model_reset();
        drive_and_check();
        chk("reset_out_valid", 64'(bus.out_valid), 64'h0);
        chk("reset_stall", 64'(bus.stall), 64'h0);
        chk("reset_long_cnt", 64'(bus.long_cnt), 64'h0);
        chk("reset_payload", bus.stage_payload, 64'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Load first instruction
        s_pay = 64'h100;
        step();
        // Back-to-back ALU: EXE beats WB for r3
        s_pay = 64'h104; s_src[0] = 5'd3; s_need = 2'b01;
        s_fwe = 3'b101; s_faddr[0] = 5'd3; s_fdata[0] = 32'h11; s_faddr[2] = 5'd3; s_fdata[2] = 32'h22;
        drive_and_check();
        chk("d1_src", 64'(bus.src_value[31:0]), 64'h11);
        chk("d1_stall", 64'(bus.stall), 64'h0);
        advance();
        // Load-use on r5
        clear_stim(); s_pay = 64'h108; s_src[0] = 5'd5; s_need = 2'b01;
        s_fwe = 3'b001; s_faddr[0] = 5'd5; s_pend = 3'b001;
        drive_and_check();
        chk("d2_stall", 64'(bus.stall), 64'h1);
        chk("d2_out_valid", 64'(bus.out_valid), 64'h0);
        advance();
        s_fwe = 3'b010; s_pend = 3'b000; s_faddr[0] = 5'd0; s_faddr[1] = 5'd5; s_fdata[1] = 32'hABCD;
        drive_and_check();
        chk("d2_src", 64'(bus.src_value[31:0]), 64'hABCD);
        chk("d2_fire", 64'(bus.out_valid), 64'h1);
        advance();
        // Divide to r7 and its consumer
        clear_stim(); s_pay = 64'h10C; s_long = 1; s_dst_we = 1; s_dst = 5'd7;
        step();
        clear_stim(); s_pay = 64'h110; s_src[0] = 5'd7; s_need = 2'b01;
        drive_and_check();
        chk("d3_cnt1", 64'(bus.long_cnt), 64'h1);
        chk("d3_stall", 64'(bus.stall), 64'h1);
        advance();
        s_done = 1; s_daddr = 5'd7;
        drive_and_check();
        chk("d3_stall_done", 64'(bus.stall), 64'h1);
        advance();
        s_done = 0; s_fwe = 3'b100; s_faddr[2] = 5'd7; s_fdata[2] = 32'h77;
        drive_and_check();
        chk("d3_src", 64'(bus.src_value[31:0]), 64'h77);
        chk("d3_cnt0", 64'(bus.long_cnt), 64'h0);
        chk("d3_nostall", 64'(bus.stall), 64'h0);
        advance();
        // Saturate the long-op counter
        clear_stim(); s_long = 1;
        step();
        step();
        drive_and_check();
        chk("d4_full_stall", 64'(bus.stall), 64'h1);
        chk("d4_cnt2", 64'(bus.long_cnt), 64'h2);
        advance();
        s_done = 1;
        drive_and_check();
        chk("d4_stall_on_done", 64'(bus.stall), 64'h1);
        advance();
        drive_and_check();
        chk("d4_fire_with_done", 64'(bus.out_valid), 64'h1);
        advance();
        s_long = 0;
        drive_and_check();
        chk("d4_cnt_net", 64'(bus.long_cnt), 64'h1);
        advance();
        s_done = 0;
        drive_and_check();
        chk("d4_cnt_drained", 64'(bus.long_cnt), 64'h0);
        advance();
        // Flush with an outstanding divide to r9
        clear_stim(); s_long = 1; s_dst_we = 1; s_dst = 5'd9;
        step();
        clear_stim(); s_flush = 1; s_oallow = 0; s_pay = 64'h200;
        step();
        clear_stim(); s_pay = 64'h204;
        drive_and_check();
        chk("d5_flushed", 64'(bus.out_valid), 64'h0);
        chk("d5_allowin", 64'(bus.in_allowin), 64'h1);
        chk("d5_cnt_kept", 64'(bus.long_cnt), 64'h1);
        advance();
        s_src[0] = 5'd9; s_need = 2'b01;
        drive_and_check();
        chk("d5_sb_kept", 64'(bus.stall), 64'h1);
        advance();
        s_done = 1; s_daddr = 5'd9;
        step();
        // r0 never forwards or stalls
        clear_stim(); s_src[0] = 5'd0; s_need = 2'b01; s_rf[0] = 32'h1234;
        s_fwe = 3'b001; s_faddr[0] = 5'd0; s_fdata[0] = 32'h55; s_pend = 3'b001;
        drive_and_check();
        chk("d6_r0_value", 64'(bus.src_value[31:0]), 64'h0);
        chk("d6_r0_stall", 64'(bus.stall), 64'h0);
        advance();
        // Reset in the middle of a scoreboard stall
        clear_stim(); s_long = 1; s_dst_we = 1; s_dst = 5'd4; s_pay = 64'h300;
        step();
        clear_stim(); s_src[0] = 5'd4; s_need = 2'b01;
        drive_and_check();
        chk("d6_pre_stall", 64'(bus.stall), 64'h1);
        #1 resetn = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_stall", 64'(bus.stall), 64'h0);
        chk("rst_cnt", 64'(bus.long_cnt), 64'h0);
        chk("rst_payload", bus.stage_payload, 64'h0);
        chk("rst_allowin", 64'(bus.in_allowin), 64'h1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        // Late completion from before reset must not underflow
        clear_stim(); s_inv = 0; s_done = 1; s_daddr = 5'd4;
        step();
        s_done = 0;
        drive_and_check();
        chk("late_done_cnt", 64'(bus.long_cnt), 64'h0);
        advance();

        // Randomized run
        for (int n = 0; n < 4000; n++) begin
            clear_stim();
            if (m_valid) begin
                s_src[0] = {2'b0, m_pay[2:0]};
                s_src[1] = {2'b0, m_pay[5:3]};
                s_need   = m_pay[7:6];
                s_dst_we = m_pay[8];
                s_dst    = {2'b0, m_pay[11:9]};
                s_long   = (m_pay[13:12] == 2'b00);
            end
            for (int p = 0; p < 2; p++) s_rf[p] = $urandom;
            for (int i = 0; i < 3; i++) begin
                s_fwe[i]   = ($urandom_range(0, 1) == 1);
                s_faddr[i] = 5'($urandom_range(0, 7));
                s_fdata[i] = $urandom;
                s_pend[i]  = ($urandom_range(0, 7) == 0);
            end
            if (q.size() > 0 && $urandom_range(0, 3) == 0) begin
                s_done  = 1;
                s_daddr = 5'(q[$urandom_range(0, q.size() - 1)]);
            end else if (q.size() == 0 && $urandom_range(0, 15) == 0) begin
                s_done  = 1;
                s_daddr = 5'($urandom_range(0, 7));
            end
            s_inv    = ($urandom_range(0, 3) != 0);
            s_pay    = {$urandom, $urandom};
            s_flush  = ($urandom_range(0, 11) == 0);
            s_oallow = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
